// File: rtl/wb_queue.sv
// Write-back merge unit: pipeline writes (port A) win the regfile write port;
// long-latency results (port B) wait in a small FIFO and drain into idle cycles.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_we,
  input  logic [AW-1:0]          a_waddr,
  input  logic [DW-1:0]          a_wdata,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_waddr,
  input  logic [DW-1:0]          b_wdata,
  output logic                   we,
  output logic [AW-1:0]          waddr,
  output logic [DW-1:0]          wdata,
  input  logic [AW-1:0]          fwd_raddr1,
  output logic                   fwd_hit1,
  output logic [DW-1:0]          fwd_data1,
  input  logic [AW-1:0]          fwd_raddr2,
  output logic                   fwd_hit2,
  output logic [DW-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   stall_req
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  logic a_hit, head_present, head_live, push, pop;

  // Writes to r0 are no-ops on both ports.
  assign a_hit        = a_we && (a_waddr != '0);
  assign head_present = (count_q != '0);
  assign head_live    = live_q[rd_ptr_q];
  assign b_ready      = (count_q < CW'(DEPTH));
  assign push         = b_valid && b_ready && (b_waddr != '0);
  assign pop          = !a_hit && head_present;

  // Squash only touches entries already stored; a same-edge push is younger and stays live.
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_hit && live_q[i] && (addr_q[i] == a_waddr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (a_hit) begin
      we_d    = 1'b1;
      waddr_d = a_waddr;
      wdata_d = a_wdata;
    end else if (head_present && head_live) begin
      we_d    = 1'b1;
      waddr_d = addr_q[rd_ptr_q];
      wdata_d = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Payload needs no reset: it is only observed through live_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= b_waddr;
      data_q[wr_ptr_q] <= b_wdata;
    end
  end

  logic [2*AW-1:0] raddr_v;
  logic [1:0]      hit_v;
  logic [2*DW-1:0] data_v;

  assign raddr_v = {fwd_raddr2, fwd_raddr1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [AW-1:0] raddr;
      logic          hit;
      logic [DW-1:0] data;
      logic [PW-1:0] idx;

      assign raddr = raddr_v[gi*AW +: AW];

      // Scan oldest to youngest so the youngest live match wins.
      always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (raddr != '0) begin
          if (a_we && (a_waddr == raddr)) begin
            hit  = 1'b1;
            data = a_wdata;
          end else begin
            for (int k = 0; k < DEPTH; k++) begin
              idx = rd_ptr_q + PW'(k);
              if (live_q[idx] && (addr_q[idx] == raddr)) begin
                hit  = 1'b1;
                data = data_q[idx];
              end
            end
          end
        end
      end

      assign hit_v[gi]            = hit;
      assign data_v[gi*DW +: DW]  = data;
    end
  endgenerate

  assign fwd_hit1  = hit_v[0];
  assign fwd_data1 = data_v[0 +: DW];
  assign fwd_hit2  = hit_v[1];
  assign fwd_data2 = data_v[DW +: DW];

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign count     = count_q;
  assign stall_req = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_wb_queue.sv
// Directed table-driven bench for wb_queue: one row per clock cycle of stimulus,
// plus a hand-written asynchronous-reset sequence.
module tb_wb_queue;
  logic        clk;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  fwd_raddr1;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic [4:0]  fwd_raddr2;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fwd_raddr1(fwd_raddr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_raddr2(fwd_raddr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs held for one cycle; fwd expectations are sampled before the edge,
  // we/waddr/wdata/cnt after it.
  typedef struct {
    logic        awe;
    logic [4:0]  aad;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  bad;
    logic [31:0] bd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic        xwe;
    logic [4:0]  xwa;
    logic [31:0] xwd;
    logic [2:0]  xcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic awe, logic [4:0] aad, logic [31:0] ad,
    logic bv, logic [4:0] bad, logic [31:0] bd,
    logic [4:0] r1, logic [4:0] r2,
    logic h1, logic [31:0] d1, logic h2, logic [31:0] d2,
    logic xwe, logic [4:0] xwa, logic [31:0] xwd, logic [2:0] xcnt);
    vec_t v;
    v.awe = awe; v.aad = aad; v.ad = ad;
    v.bv = bv; v.bad = bad; v.bd = bd;
    v.r1 = r1; v.r2 = r2;
    v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    v.xwe = xwe; v.xwa = xwa; v.xwd = xwd; v.xcnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    a_we = 0; a_waddr = 0; a_wdata = 0;
    b_valid = 0; b_waddr = 0; b_wdata = 0;
    fwd_raddr1 = 0; fwd_raddr2 = 0;
  endtask

  initial begin
    // --- test 1: single port-A write ---
    vecs.push_back(mk(1, 3, 'h1234, 0, 0, 0,     3, 0,  1, 'h1234, 0, 0,    1, 3, 'h1234, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,     3, 0,  0, 0,      0, 0,    0, 3, 'h1234, 0));
    // --- test 2: B pushes while A busy, then drain ---
    vecs.push_back(mk(1, 7, 'h77, 1, 5, 'hA,    5, 7,  0, 0,    1, 'h77,   1, 7, 'h77, 1));
    vecs.push_back(mk(1, 7, 'h77, 1, 6, 'hB,    5, 6,  1, 'hA,  0, 0,      1, 7, 'h77, 2));
    vecs.push_back(mk(1, 7, 'h77, 0, 0, 0,      5, 6,  1, 'hA,  1, 'hB,    1, 7, 'h77, 2));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      5, 6,  1, 'hA,  1, 'hB,    1, 5, 'hA,  1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      5, 6,  0, 0,    1, 'hB,    1, 6, 'hB,  0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      5, 6,  0, 0,    0, 0,      0, 6, 'hB,  0));
    // --- test 3: fill to full, 5th offer refused, drain ---
    vecs.push_back(mk(1, 8, 'h88, 1, 10, 'h100, 10, 0,  0, 0,      0, 0,      1, 8, 'h88, 1));
    vecs.push_back(mk(1, 8, 'h88, 1, 11, 'h101, 10, 0,  1, 'h100,  0, 0,      1, 8, 'h88, 2));
    vecs.push_back(mk(1, 8, 'h88, 1, 12, 'h102, 10, 0,  1, 'h100,  0, 0,      1, 8, 'h88, 3));
    vecs.push_back(mk(1, 8, 'h88, 1, 13, 'h103, 10, 0,  1, 'h100,  0, 0,      1, 8, 'h88, 4));
    vecs.push_back(mk(1, 8, 'h88, 1, 14, 'h104, 14, 13, 0, 0,      1, 'h103,  1, 8, 'h88, 4));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      10, 13, 1, 'h100,  1, 'h103,  1, 10, 'h100, 3));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      11, 13, 1, 'h101,  1, 'h103,  1, 11, 'h101, 2));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      12, 13, 1, 'h102,  1, 'h103,  1, 12, 'h102, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      13, 13, 1, 'h103,  1, 'h103,  1, 13, 'h103, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,      13, 0,  0, 0,      0, 0,      0, 13, 'h103, 0));
    // --- test 5: youngest-match forwarding, A overrides, squash of both ---
    vecs.push_back(mk(0, 0, 0,     1, 4, 1,  4, 0,  0, 0,     0, 0,  0, 13, 'h103, 1));
    vecs.push_back(mk(1, 20, 'h20, 1, 4, 2,  4, 0,  1, 1,     0, 0,  1, 20, 'h20,  2));
    vecs.push_back(mk(1, 20, 'h20, 0, 0, 0,  4, 0,  1, 2,     0, 0,  1, 20, 'h20,  2));
    vecs.push_back(mk(1, 4, 3,     0, 0, 0,  4, 0,  1, 3,     0, 0,  1, 4,  3,     2));
    vecs.push_back(mk(1, 0, 'h55,  0, 0, 0,  4, 0,  0, 0,     0, 0,  0, 4,  3,     1));
    vecs.push_back(mk(0, 0, 0,     0, 0, 0,  4, 0,  0, 0,     0, 0,  0, 4,  3,     0));
    // --- test 4: squash of older entry, same-edge push survives ---
    vecs.push_back(mk(0, 0, 0,       1, 9, 'hDEAD, 9, 9, 0, 0,       0, 0,       0, 4, 3,       1));
    vecs.push_back(mk(1, 9, 'hBEEF,  1, 9, 'hCAFE, 9, 9, 1, 'hBEEF,  1, 'hBEEF,  1, 9, 'hBEEF,  2));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,     9, 9, 1, 'hCAFE,  1, 'hCAFE,  0, 9, 'hBEEF,  1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,     9, 9, 1, 'hCAFE,  1, 'hCAFE,  1, 9, 'hCAFE,  0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,     9, 9, 0, 0,       0, 0,       0, 9, 'hCAFE,  0));
    // --- simultaneous push and pop ---
    vecs.push_back(mk(0, 0, 0, 1, 15, 'hF,  15, 16, 0, 0,   0, 0,     0, 9,  'hCAFE, 1));
    vecs.push_back(mk(0, 0, 0, 1, 16, 'h16, 15, 16, 1, 'hF, 0, 0,     1, 15, 'hF,    1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,     15, 16, 0, 0,   1, 'h16,  1, 16, 'h16,   0));

    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we",     {31'd0, we},        32'd0);
    chk("rst_waddr",  {27'd0, waddr},     32'd0);
    chk("rst_wdata",  wdata,              32'd0);
    chk("rst_count",  {29'd0, count},     32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_b_ready", {31'd0, b_ready},  32'd1);
    chk("rst_stall",   {31'd0, stall_req}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      a_we = vecs[i].awe; a_waddr = vecs[i].aad; a_wdata = vecs[i].ad;
      b_valid = vecs[i].bv; b_waddr = vecs[i].bad; b_wdata = vecs[i].bd;
      fwd_raddr1 = vecs[i].r1; fwd_raddr2 = vecs[i].r2;
      #1;
      chk($sformatf("v%0d_hit1", i),  {31'd0, fwd_hit1}, {31'd0, vecs[i].h1});
      chk($sformatf("v%0d_data1", i), fwd_data1,         vecs[i].d1);
      chk($sformatf("v%0d_hit2", i),  {31'd0, fwd_hit2}, {31'd0, vecs[i].h2});
      chk($sformatf("v%0d_data2", i), fwd_data2,         vecs[i].d2);
      @(negedge clk);
      chk($sformatf("v%0d_we", i),    {31'd0, we},       {31'd0, vecs[i].xwe});
      chk($sformatf("v%0d_waddr", i), {27'd0, waddr},    {27'd0, vecs[i].xwa});
      chk($sformatf("v%0d_wdata", i), wdata,             vecs[i].xwd);
      chk($sformatf("v%0d_count", i), {29'd0, count},    {29'd0, vecs[i].xcnt});
      chk($sformatf("v%0d_b_ready", i), {31'd0, b_ready}, {31'd0, (vecs[i].xcnt < 3'd4)});
      chk($sformatf("v%0d_stall", i), {31'd0, stall_req}, {31'd0, (vecs[i].xcnt == 3'd4)});
      $display("vec %0d: we=%0d waddr=%0d wdata=%h count=%0d hit1=%0d hit2=%0d",
               i, we, waddr, wdata, count, fwd_hit1, fwd_hit2);
    end

    // --- asynchronous reset with three entries queued ---
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      a_we = 1; a_waddr = 21; a_wdata = 32'h21;
      b_valid = 1; b_waddr = 5'(17 + i); b_wdata = 32'h170 + i;
      @(negedge clk);
    end
    drive_idle();
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_we",      {31'd0, we},      32'd0);
    chk("async_rst_waddr",   {27'd0, waddr},   32'd0);
    chk("async_rst_wdata",   wdata,            32'd0);
    chk("async_rst_count",   {29'd0, count},   32'd0);
    chk("async_rst_b_ready", {31'd0, b_ready}, 32'd1);
    $display("async reset: we=%0d count=%0d b_ready=%0d", we, count, b_ready);
    @(negedge clk);
    rst = 1'b1;
    fwd_raddr1 = 17; fwd_raddr2 = 19;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("post_rst%0d_hit1", i), {31'd0, fwd_hit1}, 32'd0);
      chk($sformatf("post_rst%0d_hit2", i), {31'd0, fwd_hit2}, 32'd0);
      @(negedge clk);
      chk($sformatf("post_rst%0d_we", i),    {31'd0, we},    32'd0);
      chk($sformatf("post_rst%0d_count", i), {29'd0, count}, 32'd0);
      $display("post-reset cycle %0d: we=%0d count=%0d", i, we, count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
